// File: rtl/step_pkg.sv
// Shared definitions for the multi-cycle pipeline steps: the common
// start/done state machine encoding and the product saturation helper.
package step_pkg;

  localparam int DATA_W = 8;
  // Widest data path the saturation helper supports.
  localparam int MAX_W  = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY     = 2'd1,
    DONE     = 2'd2,
    WAIT_LOW = 2'd3
  } step_state_e;

  // Clamp a double-width unsigned accumulator to w bits: any set bit at or
  // above position w means overflow and yields all ones in the low w bits.
  // Callers zero-extend their accumulator to 2*MAX_W and keep the low w bits.
  function automatic logic [MAX_W-1:0] saturate(input logic [2*MAX_W-1:0] acc,
                                                input int w);
    logic [MAX_W-1:0] lo_mask;
    logic             ovf;
    lo_mask = '0;
    ovf     = 1'b0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) lo_mask[i] = 1'b1;
    end
    for (int i = 0; i < 2*MAX_W; i++) begin
      if (i >= w && acc[i]) ovf = 1'b1;
    end
    return ovf ? lo_mask : (acc[MAX_W-1:0] & lo_mask);
  endfunction

endpackage

// File: rtl/seq_mult_step.sv
// Multi-cycle multiply-by-constant step. Captures the operand on a start
// request, runs a WIDTH-iteration shift-add, then presents the saturated or
// truncated product with a one-cycle done pulse. A request held past done
// parks in WAIT_LOW so it cannot launch a second operation.
module seq_mult_step
  import step_pkg::*;
#(
  parameter int          WIDTH = DATA_W,
  parameter int unsigned COEF  = 3,
  parameter bit          SAT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data,
  output logic             done
);

  localparam int               AW     = 2 * WIDTH;
  localparam int               CNT_W  = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] COEF_V = WIDTH'(COEF);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(WIDTH - 1);

  step_state_e      state_q;
  logic [AW-1:0]    acc_q;
  logic [AW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] out_q;
  logic             done_q;

  logic [AW-1:0]    acc_d;
  logic [WIDTH-1:0] result_d;

  // Accumulator value after this cycle's conditional add.
  always_comb begin
    acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  end

  // Final product as it will be presented, including the last iteration's add.
  always_comb begin
    if (SAT) begin
      result_d = WIDTH'(saturate((2*MAX_W)'(acc_d), WIDTH));
    end else begin
      result_d = acc_d[WIDTH-1:0];
    end
  end

  // Handshake FSM and shift-add datapath; cnt_q decides when BUSY ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, in_data};
            mplier_q <= COEF_V;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          if (!start) begin
            // Request withdrawn: abandon the operation, keep the old result.
            state_q <= IDLE;
          end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
              out_q   <= result_d;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          state_q <= start ? WAIT_LOW : IDLE;
        end
        WAIT_LOW: begin
          if (!start) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign out_data = out_q;
  assign done     = done_q;

endmodule

// File: tb/tb_seq_mult_step.sv
// Bench for seq_mult_step: six instances (main COEF=3 SAT=1, one SAT=0, and a
// four-step chain). Stimulus pushes expected products into per-instance
// queues; a monitor pops and compares whenever done is seen.
module tb_seq_mult_step;
  import step_pkg::*;

  localparam int N = 6;

  logic       clk;
  logic       rst_n;
  logic       start_s  [N];
  logic [7:0] in_s     [N];
  logic [7:0] out_s    [N];
  logic       done_s   [N];

  logic [7:0] exp_q [N][$];
  int         done_cnt [N];
  int         errors;
  int         checks;

  for (genvar g = 0; g < N; g++) begin : g_dut
    seq_mult_step #(
      .WIDTH(8),
      .COEF (3),
      .SAT  ((g == 1) ? 1'b0 : 1'b1)
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start_s[g]),
      .in_data (in_s[g]),
      .out_data(out_s[g]),
      .done    (done_s[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst_n && done_s[i]) begin
        done_cnt[i]++;
        if (exp_q[i].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done inst %0d: out_data=%0d with nothing expected", i, out_s[i]);
        end else begin
          check($sformatf("result_inst%0d", i), int'(out_s[i]), int'(exp_q[i].pop_front()));
        end
      end
    end
  end

  // One operation: raise start, measure latency to done, optionally hold
  // start for extra cycles, then release.
  task automatic run_op(input int inst, input logic [7:0] d, input logic [7:0] expv,
                        input int hold, input string nm);
    int lat;
    lat = 0;
    exp_q[inst].push_back(expv);
    @(negedge clk);
    in_s[inst]    = d;
    start_s[inst] = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (done_s[inst]) begin
        lat = k;
        break;
      end
    end
    check({nm, "_latency"}, lat, 9);
    for (int h = 1; h <= hold; h++) begin
      @(posedge clk);
      #1;
      if (h == 1 && inst == 0) check({nm, "_wait_low"}, int'(g_dut[0].u_dut.state_q), int'(WAIT_LOW));
    end
    start_s[inst] = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int         c0;
    logic [7:0] din;
    logic [7:0] chain_exp [4];
    chain_exp[0] = 8'd6;
    chain_exp[1] = 8'd18;
    chain_exp[2] = 8'd54;
    chain_exp[3] = 8'd162;
    errors = 0;
    checks = 0;
    for (int i = 0; i < N; i++) begin
      start_s[i]  = 1'b0;
      in_s[i]     = 8'd0;
      done_cnt[i] = 0;
    end
    rst_n = 1'b0;
    #2;
    for (int i = 0; i < N; i++) begin
      check($sformatf("reset_done_inst%0d", i), int'(done_s[i]), 0);
      check($sformatf("reset_out_inst%0d", i), int'(out_s[i]), 0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Basic operation: 5*3 = 15, start dropped in the done cycle.
    run_op(0, 8'd5, 8'd15, 0, "mul5");
    check("out_hold_after_done", int'(out_s[0]), 15);

    // Overflow: 100*3 = 300 -> saturate to 255, or wrap to 44.
    run_op(0, 8'd100, 8'd255, 0, "sat_on");
    run_op(1, 8'd100, 8'd44, 0, "sat_off");

    // Held request: one done only, result stays 15.
    c0 = done_cnt[0];
    run_op(0, 8'd5, 8'd15, 20, "held");
    check("held_single_done", done_cnt[0] - c0, 1);
    check("held_out_stable", int'(out_s[0]), 15);

    // Abort in the fourth BUSY cycle.
    c0 = done_cnt[0];
    @(negedge clk);
    in_s[0]    = 8'd7;
    start_s[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    @(posedge clk);
    #1;
    check("abort_idle", int'(g_dut[0].u_dut.state_q), int'(IDLE));
    repeat (15) @(posedge clk);
    check("abort_no_done", done_cnt[0] - c0, 0);
    check("abort_out_kept", int'(out_s[0]), 15);

    // Asynchronous reset in the middle of BUSY.
    @(negedge clk);
    in_s[0]    = 8'd9;
    start_s[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_done", int'(done_s[0]), 0);
    check("async_rst_out", int'(out_s[0]), 0);
    start_s[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run_op(0, 8'd0, 8'd0, 0, "zero");

    // Four chained steps fed like the controller does: 2*3^4 = 162.
    din = 8'd2;
    for (int s = 0; s < 4; s++) begin
      run_op(s + 2, din, chain_exp[s], 0, $sformatf("chain%0d", s));
      din = out_s[s + 2];
    end
    check("chain_final", int'(out_s[5]), 162);
    for (int s = 2; s < N; s++) check($sformatf("chain_done_count%0d", s), done_cnt[s], 1);

    repeat (3) @(posedge clk);
    for (int i = 0; i < N; i++) check($sformatf("queue_drain%0d", i), exp_q[i].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_mult_step.md
# seq_mult_step

Responder end of the step start/done handshake. The sequencing controller raises `start` and holds it while it waits for a one-cycle `done` pulse. This block captures `in_data` and multiplies it by a constant coefficient with a shift-add datapath over WIDTH cycles. It then returns the saturated or truncated product on `out_data` together with `done`. It drops into any step slot of the add/mul/special/end pipeline in place of a single-cycle step.

## Interface
- WIDTH, 8: data width of `in_data`/`out_data`; also the number of multiply iterations.
- COEF, 3: unsigned multiplier constant, WIDTH bits.
- SAT, 1: 1 = saturate the product to 2^WIDTH-1 on overflow; 0 = keep the low WIDTH bits.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  level request from the controller; held high until the cycle after `done`.
- in_data  in  WIDTH  operand; sampled only on the capture edge.
- out_data  out  WIDTH  registered result; holds its value until the next completed operation.
- done  out  1  registered one-cycle completion pulse.

## Operation
- States: IDLE, BUSY, DONE, WAIT_LOW.
- IDLE, start=1: capture the operand and move to BUSY.
  - mcand = {WIDTH'b0, in_data} (2·WIDTH bits); mplier = COEF; acc = 0; cnt = 0.
- BUSY, one iteration per cycle:
  - if mplier[0] = 1, acc += mcand;
  - mcand <<= 1; mplier >>= 1; cnt++.
- BUSY, after iteration WIDTH-1: go to DONE, register `done`=1, register `out_data` = final result.
  - Final result = acc, including the last iteration's add.
  - SAT=1: if acc[2W-1:W] ≠ 0, out_data = all ones, else acc[W-1:0].
  - SAT=0: out_data = acc[W-1:0].
- Abort: start=0 in any BUSY cycle returns to IDLE next edge. No `done`; `out_data` unchanged.
- DONE (lasts one cycle, `done`=1):
  - start=1 → WAIT_LOW;
  - start=0 → IDLE.
- WAIT_LOW: ignores start=1 and only returns to IDLE when start=0, so a held request never produces a second operation.
- acc is 2·WIDTH bits wide, so the accumulation never wraps before the saturation check.
- COEF=0 or in_data=0 still takes the full WIDTH cycles and yields 0.
- Illegal state encoding → IDLE.

## Timing
- Reset (async, any state, including mid-BUSY):
  - state=IDLE, `done`=0, `out_data`=0;
  - acc, mcand, mplier, cnt cleared.
- Latency: start first sampled high at the end of cycle t. BUSY occupies cycles t+1..t+WIDTH. `done`=1 and the new `out_data` appear in cycle t+WIDTH+1 (9 cycles for WIDTH=8).
- `done` is high for exactly one cycle per completed operation. `out_data` is valid in that cycle and stays stable afterwards.
- Controller contract: the controller latches `out_data` on the `done` edge and deasserts start the following cycle (DONE → IDLE path). A start still high in DONE goes to WAIT_LOW.
- Minimum request spacing: start must be low for at least one cycle between operations. A new operation can begin at the earliest two cycles after `done`.
- No combinational path from any input to any output.

## Structure
- Shared package `step_pkg`:
  - state enum (IDLE/BUSY/DONE/WAIT_LOW), reused by the other multi-cycle steps;
  - default DATA_W=8;
  - saturate(acc) function, shared with the other multi-cycle steps.
- Single module; no sub-module required. The shift-add datapath and the FSM stay together in one block because cnt drives the FSM exit.

## Test plan
- COEF=3, SAT=1, in_data=5, start held until the cycle after done → done exactly once in cycle t+9, out_data=15.
- COEF=3, in_data=100 → SAT=1 gives out_data=255; SAT=0 gives out_data=44 (300 mod 256).
- COEF=3, start held high for 20 cycles after done → WAIT_LOW entered, no second done, out_data stays 15.
- Abort: start drops at BUSY cycle 4 with in_data=7 → no done, out_data keeps its previous value (15), state is IDLE the next cycle.
- rst_n pulsed low mid-BUSY → done=0 and out_data=0 immediately (asynchronous). A fresh start with in_data=0 then completes with out_data=0 after 9 cycles.
- Four of these blocks chained behind the sequencing controller, data_in=2 → controller done with out_data=162 (2·3⁴); each step's done observed exactly once.
